// File: rtl/cplx_mult_arbiter_pkg.sv
// Shared types and field layout for the two-port complex-multiplier arbiter.
// FSM state encoding plus operand/result field offsets as functions of DATA_WIDTH.
package cplx_mult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;

  // Operand word is {op1_re, op1_im, op2_re, op2_im}; idx 0 is op1_re (MSB field).
  function automatic int op_field_lsb(input int dw, input int idx);
    return (3 - idx) * dw;
  endfunction

  // Result word is {res_re, res_im}, each 2*dw wide.
  function automatic int res_re_lsb(input int dw);
    return 2 * dw;
  endfunction

  function automatic int res_im_lsb(input int dw);
    return 0 * dw;
  endfunction

endpackage

// File: rtl/cplx_mult_arbiter_if.sv
// Bundle of requester, result and multiplier handshakes around the arbiter.
// master = arbiter side, slave = requesters plus multiplier side.
interface cplx_mult_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int W = 4 * DATA_WIDTH;

  logic         req0_val;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_val;
  logic         req1_ready;
  logic [W-1:0] req1_data;

  logic         res0_val;
  logic         res0_ready;
  logic [W-1:0] res0_data;
  logic         res1_val;
  logic         res1_ready;
  logic [W-1:0] res1_data;

  logic         mult_op_val;
  logic         mult_op_ready;
  logic [W-1:0] mult_op_data;
  logic         mult_res_val;
  logic         mult_res_ready;
  logic [W-1:0] mult_res_data;

  modport master (
    input  req0_val, req0_data, req1_val, req1_data,
    output req0_ready, req1_ready,
    output res0_val, res0_data, res1_val, res1_data,
    input  res0_ready, res1_ready,
    output mult_op_val, mult_op_data, mult_res_ready,
    input  mult_op_ready, mult_res_val, mult_res_data
  );

  modport slave (
    output req0_val, req0_data, req1_val, req1_data,
    input  req0_ready, req1_ready,
    input  res0_val, res0_data, res1_val, res1_data,
    output res0_ready, res1_ready,
    input  mult_op_val, mult_op_data, mult_res_ready,
    output mult_op_ready, mult_res_val, mult_res_data
  );

endinterface

// File: rtl/cplx_mult_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, on contention the port
// that was not granted last wins. Purely combinational; history lives in the parent.
module rr_arbiter_2 (
  input  logic [1:0] val_i,
  input  logic       last_grant_i,
  output logic       sel_o,
  output logic       any_val_o
);

  assign any_val_o = |val_i;
  assign sel_o     = (&val_i) ? ~last_grant_i : val_i[1];

endmodule

// File: rtl/cplx_mult_arbiter.sv
// Shares one complex multiplier between two requesters, one transaction in flight.
// Optional per-port delivery counters (cnt0/cnt1) when CPLX_ARB_STATS_EN is defined.
module cplx_mult_arbiter
  import cplx_mult_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  // sw_rst is also wired to the multiplier's own sw_rst by the integrating level.
  input  logic sw_rst,
  cplx_mult_arbiter_if.master bus,
  output logic busy
`ifdef CPLX_ARB_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  localparam int W = 4 * DATA_WIDTH;

  arb_state_e   state_q;
  logic         grant_q;
  logic         last_grant_q;
  logic         op_val_q;
  logic         res_rdy_q;
  logic [1:0]   res_val_q;
  logic [W-1:0] op_q;
  logic [W-1:0] res0_q;
  logic [W-1:0] res1_q;

  logic sel;
  logic any_val;
  logic accept;
  logic res_ready_sel;

  rr_arbiter_2 u_rr (
    .val_i        ({bus.req1_val, bus.req0_val}),
    .last_grant_i (last_grant_q),
    .sel_o        (sel),
    .any_val_o    (any_val)
  );

  // Ready is combinational so a requester is taken in the same cycle it wins.
  assign accept         = (state_q == IDLE) && any_val && !sw_rst && !rst;
  assign bus.req0_ready = accept && !sel;
  assign bus.req1_ready = accept && sel;
  assign res_ready_sel  = grant_q ? bus.res1_ready : bus.res0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_val_q     <= 1'b0;
      res_rdy_q    <= 1'b0;
      res_val_q    <= '0;
      op_q         <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else if (sw_rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_val_q     <= 1'b0;
      res_rdy_q    <= 1'b0;
      res_val_q    <= '0;
      op_q         <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= sel ? bus.req1_data : bus.req0_data;
            grant_q  <= sel;
            op_val_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mult_op_ready) begin
            op_val_q  <= 1'b0;
            res_rdy_q <= 1'b1;
            state_q   <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // Each port keeps its own result register so the idle port's data holds.
          if (bus.mult_res_val) begin
            res_rdy_q          <= 1'b0;
            res_val_q[grant_q] <= 1'b1;
            if (grant_q) res1_q <= bus.mult_res_data;
            else         res0_q <= bus.mult_res_data;
            state_q            <= DELIVER;
          end
        end
        DELIVER: begin
          if (res_ready_sel) begin
            res_val_q    <= '0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy               = (state_q != IDLE);
  assign bus.mult_op_val    = op_val_q;
  assign bus.mult_op_data   = op_q;
  assign bus.mult_res_ready = res_rdy_q;
  assign bus.res0_val       = res_val_q[0];
  assign bus.res1_val       = res_val_q[1];
  assign bus.res0_data      = res0_q;
  assign bus.res1_data      = res1_q;

`ifdef CPLX_ARB_STATS_EN
  logic deliver_hs;
  assign deliver_hs = (state_q == DELIVER) && res_ready_sel;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (sw_rst)
        cnt_q <= '0;
      else if (deliver_hs && (grant_q == 1'(gi)))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt0 = g_cnt[0].cnt_q;
  assign cnt1 = g_cnt[1].cnt_q;
`endif

endmodule

// File: tb/tb_cplx_mult_arbiter.sv
// Directed bench for cplx_mult_arbiter; the bench plays both requesters and the multiplier.
// Counter checks run only when CPLX_ARB_STATS_EN is defined.
module tb_cplx_mult_arbiter;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic sw_rst;
  logic busy;
`ifdef CPLX_ARB_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int errors = 0;
  int checks = 0;
  int del0   = 0;
  int del1   = 0;

  cplx_mult_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  cplx_mult_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_rst (sw_rst),
    .bus    (bus),
    .busy   (busy)
`ifdef CPLX_ARB_STATS_EN
    ,
    .cnt0   (cnt0),
    .cnt1   (cnt1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.res0_val && bus.res0_ready) del0++;
    if (bus.res1_val && bus.res1_ready) del1++;
  end

  task automatic init_inputs();
    bus.req0_val = 0; bus.req0_data = '0;
    bus.req1_val = 0; bus.req1_data = '0;
    bus.res0_ready = 0; bus.res1_ready = 0;
    bus.mult_op_ready = 0; bus.mult_res_val = 0; bus.mult_res_data = '0;
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask

  // Called just after a negedge; returns at the negedge following the handshake edge.
  task automatic send_req(input int port, input logic [31:0] data, output bit ok);
    ok = 0;
    if (port == 0) begin bus.req0_val = 1; bus.req0_data = data; end
    else           begin bus.req1_val = 1; bus.req1_data = data; end
    for (int n = 0; n < 20; n++) begin
      #1;
      if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req0_val = 0;
    bus.req1_val = 0;
  endtask

  // Acts as a multiplier with no op stall and one-cycle result latency.
  task automatic serve_mult(input logic [31:0] result, output logic [31:0] op_seen, output bit ok);
    ok = 0;
    op_seen = '0;
    for (int n = 0; n < 20; n++) begin
      if (bus.mult_op_val) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    bus.mult_op_ready = 1;
    op_seen = bus.mult_op_data;
    @(negedge clk);
    bus.mult_op_ready = 0;
    bus.mult_res_val  = 1;
    bus.mult_res_data = result;
    @(negedge clk);
    bus.mult_res_val  = 0;
  endtask

  task automatic collect(input int port, output logic [31:0] data, output bit ok);
    ok = 0;
    data = '0;
    for (int n = 0; n < 20; n++) begin
      if ((port == 0 && bus.res0_val) || (port == 1 && bus.res1_val)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    if (port == 0) begin bus.res0_ready = 1; data = bus.res0_data; end
    else           begin bus.res1_ready = 1; data = bus.res1_data; end
    @(negedge clk);
    bus.res0_ready = 0;
    bus.res1_ready = 0;
  endtask

  task automatic test_reset();
    init_inputs();
    sw_rst = 0;
    rst = 1;
    bus.req0_val = 1; bus.req1_val = 1; bus.mult_res_val = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_busy: got %b expected 000", {busy, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.mult_op_val, bus.mult_res_ready, bus.res0_val, bus.res1_val} !== 4'b0000) begin
      errors++; $display("FAIL reset_vals: got %b expected 0000",
                         {bus.mult_op_val, bus.mult_res_ready, bus.res0_val, bus.res1_val});
    end
    checks++;
    if ({bus.mult_op_data, bus.res0_data, bus.res1_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.mult_op_data, bus.res0_data, bus.res1_data});
    end
    init_inputs();
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; logic [31:0] op_seen, data; int d0, d1;
    d0 = del0; d1 = del1;
    send_req(0, 32'h03020104, ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++; $display("FAIL single_accept: got ok=%0d busy=%b expected ok=1 busy=1", ok, busy);
    end
    serve_mult(32'hFFFB000E, op_seen, ok);
    checks++;
    if (!ok || op_seen !== 32'h03020104) begin
      errors++; $display("FAIL single_op: got %h expected 03020104", op_seen);
    end
    checks++;
    if ({bus.res0_val, bus.res1_val} !== 2'b10) begin
      errors++; $display("FAIL single_latency: got res_val=%b expected 10", {bus.res0_val, bus.res1_val});
    end
    collect(0, data, ok);
    checks++;
    if (!ok || data !== 32'hFFFB000E) begin
      errors++; $display("FAIL single_result: got %h expected fffb000e", data);
    end
    checks++;
    if (del0 - d0 !== 1 || del1 - d1 !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_count: got d0=%0d d1=%0d busy=%b expected 1 0 0", del0 - d0, del1 - d1, busy);
    end
  endtask

  task automatic test_contention();
    bit ok; logic [31:0] op_seen, data, exp_op, exp_res; int exp_port;
    pulse_rst();
    for (int r = 0; r < 5; r++) begin
      exp_port = r % 2;
      exp_op   = (exp_port == 0) ? (32'h11223300 | r) : (32'h44556600 | r);
      exp_res  = 32'hC0DE0000 + r;
      bus.req0_val = 1; bus.req0_data = 32'h11223300 | r;
      bus.req1_val = 1; bus.req1_data = 32'h44556600 | r;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== ((exp_port == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contention_grant[%0d]: got ready=%b expected port %0d",
                           r, {bus.req1_ready, bus.req0_ready}, exp_port);
      end
      @(negedge clk);
      bus.req0_val = 0; bus.req1_val = 0;
      serve_mult(exp_res, op_seen, ok);
      checks++;
      if (!ok || op_seen !== exp_op) begin
        errors++; $display("FAIL contention_op[%0d]: got %h expected %h", r, op_seen, exp_op);
      end
      checks++;
      if (((exp_port == 0) ? bus.res1_val : bus.res0_val) !== 1'b0) begin
        errors++; $display("FAIL contention_other_val[%0d]: got 1 expected 0", r);
      end
      collect(exp_port, data, ok);
      checks++;
      if (!ok || data !== exp_res) begin
        errors++; $display("FAIL contention_res[%0d]: got %h expected %h", r, data, exp_res);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable; int d0, d1;
    d0 = del0; d1 = del1;
    send_req(0, 32'h7F80017F, ok);
    stable = ok;
    for (int s = 0; s < 5; s++) begin
      if (bus.mult_op_val !== 1'b1 || bus.mult_op_data !== 32'h7F80017F) stable = 0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_op_stable: got val=%b data=%h expected 1 7f80017f", bus.mult_op_val, bus.mult_op_data);
    end
    bus.mult_op_ready = 1;
    @(negedge clk);
    bus.mult_op_ready = 0;
    bus.mult_res_val = 1; bus.mult_res_data = 32'h12345678;
    @(negedge clk);
    bus.mult_res_val = 0;
    stable = 1;
    for (int s = 0; s < 4; s++) begin
      if (bus.res0_val !== 1'b1 || bus.res0_data !== 32'h12345678 || bus.res1_val !== 1'b0) stable = 0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_res_stable: got val=%b data=%h expected 1 12345678", bus.res0_val, bus.res0_data);
    end
    bus.res0_ready = 1;
    @(negedge clk);
    bus.res0_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (del0 - d0 !== 1 || del1 - d1 !== 0 || bus.res0_val !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_one_delivery: got d0=%0d d1=%0d val=%b busy=%b expected 1 0 0 0",
                         del0 - d0, del1 - d1, bus.res0_val, busy);
    end
  endtask

  task automatic test_stray();
    int d0, d1;
    d0 = del0; d1 = del1;
    bus.mult_res_val = 1; bus.mult_res_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.mult_res_ready !== 1'b0) begin
      errors++; $display("FAIL stray_ready: got %b expected 0", bus.mult_res_ready);
    end
    @(negedge clk);
    bus.mult_res_val = 0;
    @(negedge clk);
    checks++;
    if ({bus.res0_val, bus.res1_val, busy} !== 3'b000 || bus.res0_data !== 32'h12345678 || del0 != d0 || del1 != d1) begin
      errors++; $display("FAIL stray_ignored: got vals=%b data=%h expected 000 12345678",
                         {bus.res0_val, bus.res1_val, busy}, bus.res0_data);
    end
  endtask

  task automatic test_sw_rst();
    bit ok; int d0, d1;
    d0 = del0; d1 = del1;
    send_req(1, 32'hA1B2C3D4, ok);
    bus.mult_op_ready = 1;
    @(negedge clk);
    bus.mult_op_ready = 0;
    checks++;
    if (!ok || busy !== 1'b1 || bus.mult_res_ready !== 1'b1) begin
      errors++; $display("FAIL swrst_in_wait: got busy=%b res_ready=%b expected 1 1", busy, bus.mult_res_ready);
    end
    sw_rst = 1; bus.mult_res_val = 1; bus.mult_res_data = 32'h55AA55AA;
    @(negedge clk);
    sw_rst = 0; bus.mult_res_val = 0;
    checks++;
    if ({busy, bus.mult_res_ready, bus.res0_val, bus.res1_val} !== 4'b0000) begin
      errors++; $display("FAIL swrst_idle: got %b expected 0000", {busy, bus.mult_res_ready, bus.res0_val, bus.res1_val});
    end
    checks++;
    if ({bus.res0_data, bus.res1_data} !== 64'h0) begin
      errors++; $display("FAIL swrst_data: got %h expected 0", {bus.res0_data, bus.res1_data});
    end
    bus.req0_val = 1; bus.req1_val = 1;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL swrst_last_grant: got ready=%b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    bus.req0_val = 0; bus.req1_val = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || del0 != d0 || del1 != d1) begin
      errors++; $display("FAIL swrst_no_delivery: got busy=%b d0=%0d d1=%0d expected 0 0 0", busy, del0 - d0, del1 - d1);
    end
  endtask

  task automatic test_async_rst();
    bit ok;
    send_req(0, 32'h0F0E0D0C, ok);
    checks++;
    if (!ok || bus.mult_op_val !== 1'b1) begin
      errors++; $display("FAIL arst_setup: got op_val=%b expected 1", bus.mult_op_val);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({bus.mult_op_val, busy} !== 2'b00 || bus.mult_op_data !== 32'h0) begin
      errors++; $display("FAIL arst_immediate: got val/busy=%b data=%h expected 00 0",
                         {bus.mult_op_val, busy}, bus.mult_op_data);
    end
    #1 rst = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mult_op_val, busy, bus.res0_val} !== 3'b000) begin
      errors++; $display("FAIL arst_stays_idle: got %b expected 000", {bus.mult_op_val, busy, bus.res0_val});
    end
  endtask

`ifdef CPLX_ARB_STATS_EN
  task automatic test_stats();
    bit ok; logic [31:0] op_seen, data;
    int ports [5] = '{0, 1, 0, 1, 0};
    pulse_rst();
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL stats_reset: got %0d %0d expected 0 0", cnt0, cnt1);
    end
    for (int t = 0; t < 5; t++) begin
      send_req(ports[t], 32'h01010101 * (t + 1), ok);
      serve_mult(32'h00000100 + t, op_seen, ok);
      collect(ports[t], data, ok);
    end
    checks++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin
      errors++; $display("FAIL stats_counts: got %0d %0d expected 3 2", cnt0, cnt1);
    end
    sw_rst = 1;
    @(negedge clk);
    sw_rst = 0;
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL stats_swrst: got %0d %0d expected 0 0", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stray();
    test_sw_rst();
    test_async_rst();
`ifdef CPLX_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
